sort_accel: RTL and testbench

SORT_ACCEL -- requirements
Module: sort_accel

---
 rtl/sort_accel_if.sv | 34 +++
 rtl/sort_accel.sv | 201 ++++++++++++++++++++
 tb/tb_sort_accel.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_accel_if.sv
// Bus bundle for sort_accel: CSR slave port, memory master port and irq.
// Modport 'master' is the accelerator's view; 'slave' is the host/memory side.
interface sort_accel_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        slave_address;
    logic              slave_read;
    logic [31:0]       slave_readdata;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic              slave_waitrequest;
    logic [31:0]       master_address;
    logic              master_read;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;
    logic              master_waitrequest;
    logic              irq;

    modport master (
        input  slave_address, slave_read, slave_write, slave_writedata,
               master_readdata, master_readdatavalid, master_waitrequest,
        output slave_readdata, slave_waitrequest, master_address, master_read,
               master_write, master_writedata, irq
    );

    modport slave (
        output slave_address, slave_read, slave_write, slave_writedata,
               master_readdata, master_readdatavalid, master_waitrequest,
        input  slave_readdata, slave_waitrequest, master_address, master_read,
               master_write, master_writedata, irq
    );
endinterface

// File: rtl/sort_accel.sv
// In-place bubble sort accelerator: CSR-programmed base/length, one outstanding
// memory read at a time, swap writes only when a pair is out of order.
//
// state | meaning
// IDLE  | waiting for CTRL start
// RD_A  | read request for element i
// WT_A  | waiting for element i data
// RD_B  | read request for element i+1
// WT_B  | waiting for element i+1 data
// CMP   | compare pair, decide swap
// WR_A  | write B to element i
// WR_B  | write A to element i+1
// NEXT  | advance pair index or finish pass
// FIN   | set done, clear busy
module sort_accel #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 1024
) (
    input logic          clk,
    input logic          rst_n,
    sort_accel_if.master bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int SH = $clog2(DATA_W / 8);
    localparam logic [31:0] STRIDE = 32'(DATA_W / 8);

    typedef enum logic [3:0] {IDLE, RD_A, WT_A, RD_B, WT_B, CMP, WR_A, WR_B, NEXT, FIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_q, base_d, passes_q, passes_d, swaps_q, swaps_d, addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic              desc_q, desc_d, sgn_q, sgn_d, irq_en_q, irq_en_d;
    logic              busy_q, busy_d, done_q, done_d, swapped_q, swapped_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wdata_q, wdata_d;

    logic [LEN_W-1:0]  len_eff;
    logic [31:0]       elem_addr, limit, passes_inc, swaps_inc;
    logic              pair_last, all_passes, greater, less, do_swap, start;

    always_comb begin
        len_eff    = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
        elem_addr  = base_q + (32'(idx_q) << SH);
        limit      = 32'(len_eff) - 32'd1 - passes_q;
        pair_last  = (32'(idx_q) + 32'd1 >= limit);
        passes_inc = (passes_q == '1) ? passes_q : passes_q + 32'd1;
        swaps_inc  = (swaps_q == '1) ? swaps_q : swaps_q + 32'd1;
        // A pass that leaves no pairs for the next one ends the sort.
        all_passes = (passes_inc >= 32'(len_eff) - 32'd1);
        greater    = sgn_q ? ($signed(a_q) > $signed(b_q)) : (a_q > b_q);
        less       = sgn_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
        do_swap    = desc_q ? less : greater;
        start      = bus.slave_write && (bus.slave_address == 4'd0) && bus.slave_writedata[0];
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        passes_d  = passes_q;
        swaps_d   = swaps_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        desc_d    = desc_q;
        sgn_d     = sgn_q;
        irq_en_d  = irq_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        swapped_d = swapped_q;
        a_d       = a_q;
        b_d       = b_q;
        wdata_d   = wdata_q;

        if (bus.slave_write) begin
            case (bus.slave_address)
                4'd1: if (!busy_q) base_d = bus.slave_writedata;
                4'd2: if (!busy_q) len_d = bus.slave_writedata[LEN_W-1:0];
                4'd3: if (bus.slave_writedata[1]) done_d = 1'b0;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: if (start) begin
                desc_d    = bus.slave_writedata[1];
                sgn_d     = bus.slave_writedata[2];
                irq_en_d  = bus.slave_writedata[3];
                busy_d    = 1'b1;
                done_d    = 1'b0;
                passes_d  = '0;
                swaps_d   = '0;
                idx_d     = '0;
                swapped_d = 1'b0;
                addr_d    = base_q;
                state_d   = (len_eff < LEN_W'(2)) ? FIN : RD_A;
            end
            RD_A: if (!bus.master_waitrequest) state_d = WT_A;
            WT_A: if (bus.master_readdatavalid) begin
                a_d     = bus.master_readdata;
                addr_d  = addr_q + STRIDE;
                state_d = RD_B;
            end
            RD_B: if (!bus.master_waitrequest) state_d = WT_B;
            WT_B: if (bus.master_readdatavalid) begin
                b_d     = bus.master_readdata;
                state_d = CMP;
            end
            CMP: if (do_swap) begin
                addr_d    = elem_addr;
                wdata_d   = b_q;
                swaps_d   = swaps_inc;
                swapped_d = 1'b1;
                state_d   = WR_A;
            end else begin
                state_d = NEXT;
            end
            WR_A: if (!bus.master_waitrequest) begin
                addr_d  = addr_q + STRIDE;
                wdata_d = a_q;
                state_d = WR_B;
            end
            WR_B: if (!bus.master_waitrequest) state_d = NEXT;
            NEXT: if (!pair_last) begin
                idx_d   = idx_q + 1'b1;
                addr_d  = elem_addr + STRIDE;
                state_d = RD_A;
            end else begin
                passes_d  = passes_inc;
                swapped_d = 1'b0;
                idx_d     = '0;
                addr_d    = base_q;
                state_d   = (!swapped_q || all_passes) ? FIN : RD_A;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            passes_q  <= '0;
            swaps_q   <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            desc_q    <= 1'b0;
            sgn_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            swapped_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            passes_q  <= passes_d;
            swaps_q   <= swaps_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            desc_q    <= desc_d;
            sgn_q     <= sgn_d;
            irq_en_q  <= irq_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            swapped_q <= swapped_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0: bus.slave_readdata = {28'd0, irq_en_q, sgn_q, desc_q, 1'b0};
                4'd1: bus.slave_readdata = base_q;
                4'd2: bus.slave_readdata = 32'(len_q);
                4'd3: bus.slave_readdata = {30'd0, done_q, busy_q};
                4'd4: bus.slave_readdata = passes_q;
                4'd5: bus.slave_readdata = swaps_q;
                default: bus.slave_readdata = '0;
            endcase
        end
    end

    assign bus.slave_waitrequest = 1'b0;
    assign bus.master_read       = (state_q == RD_A) || (state_q == RD_B);
    assign bus.master_write      = (state_q == WR_A) || (state_q == WR_B);
    assign bus.master_address    = addr_q;
    assign bus.master_writedata  = wdata_q;
    assign bus.irq               = done_q & irq_en_q;
endmodule

// File: tb/tb_sort_accel.sv
// Directed bench for sort_accel with a word-addressed memory responder that can
// stall requests and delay read data.
module tb_sort_accel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_accel_if #(.DATA_W(32)) bus ();
    sort_accel #(.DATA_W(32), .MAX_LEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [31:0] mem [0:1023];
    bit rand_mode = 1'b0;
    bit force_wait = 1'b0;
    int rd_cnt = 0, wr_cnt = 0, stall_viol = 0, stall_cnt = 0;

    // memory responder: decisions at negedge, accepted at the following posedge
    initial begin
        bit pend, prev_stall, p_rd, p_wr;
        int pdly;
        logic [31:0] pdata, p_addr, p_wd;
        pend = 0; prev_stall = 0; p_rd = 0; p_wr = 0; pdly = 0;
        pdata = '0; p_addr = '0; p_wd = '0;
        bus.master_waitrequest = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
                prev_stall = 0;
                bus.master_waitrequest = 1'b0;
                continue;
            end
            if (prev_stall) begin
                stall_cnt++;
                if (bus.master_read !== p_rd || bus.master_write !== p_wr ||
                    bus.master_address !== p_addr || (p_wr && bus.master_writedata !== p_wd))
                    stall_viol++;
            end
            if (pend) begin
                if (pdly == 0) begin
                    bus.master_readdatavalid = 1'b1;
                    bus.master_readdata = pdata;
                    pend = 0;
                end else begin
                    pdly--;
                end
            end
            bus.master_waitrequest = force_wait ? 1'b1 :
                                     (rand_mode ? 1'($urandom_range(0, 1)) : 1'b0);
            if (bus.master_read && !bus.master_waitrequest) begin
                rd_cnt++;
                pend = 1;
                pdata = mem[bus.master_address[11:2]];
                pdly = rand_mode ? int'($urandom_range(0, 5)) : 0;
            end
            if (bus.master_write && !bus.master_waitrequest) begin
                wr_cnt++;
                mem[bus.master_address[11:2]] = bus.master_writedata;
            end
            prev_stall = (bus.master_read || bus.master_write) && bus.master_waitrequest;
            p_rd = bus.master_read;
            p_wr = bus.master_write;
            p_addr = bus.master_address;
            p_wd = bus.master_writedata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_writedata = d;
        bus.slave_write = 1'b1;
        @(negedge clk);
        bus.slave_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read = 1'b1;
        #1;
        d = bus.slave_readdata;
        bus.slave_read = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        s = '0;
        while (!s[1] && n < 20000) begin
            csr_rd(4'd3, s);
            n++;
        end
        chk({tag, "_done"}, s, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] exp_arr [0:31];
        logic [31:0] t;
        int base_wr, base_rd, n;
        bus.slave_address = '0;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        bus.slave_writedata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(bus.master_read), 32'h0);
        chk("rst_write", 32'(bus.master_write), 32'h0);
        chk("rst_addr", bus.master_address, 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        rst_n = 1'b1;
        csr_rd(4'd3, r); chk("rst_status", r, 32'h0);
        csr_rd(4'd1, r); chk("rst_base", r, 32'h0);
        csr_rd(4'd2, r); chk("rst_len", r, 32'h0);
        csr_rd(4'd4, r); chk("rst_passes", r, 32'h0);
        csr_rd(4'd5, r); chk("rst_swaps", r, 32'h0);
        csr_rd(4'd0, r); chk("rst_ctrl", r, 32'h0);

        // A: [5,3,9,1] ascending unsigned with irq, start/BASE writes while busy
        mem[0] = 5; mem[1] = 3; mem[2] = 9; mem[3] = 1;
        csr_wr(4'd1, 32'h6000);
        csr_wr(4'd2, 32'd4);
        csr_rd(4'd1, r); chk("A_base_rb", r, 32'h6000);
        csr_rd(4'd7, r); chk("A_unmapped", r, 32'h0);
        csr_wr(4'd0, 32'h9);
        csr_rd(4'd3, r); chk("A_busy", r, 32'h1);
        csr_wr(4'd0, 32'h1);
        csr_wr(4'd1, 32'h1234);
        csr_wr(4'd2, 32'd2);
        wait_done("A");
        chk("A_m0", mem[0], 32'd1);
        chk("A_m1", mem[1], 32'd3);
        chk("A_m2", mem[2], 32'd5);
        chk("A_m3", mem[3], 32'd9);
        csr_rd(4'd5, r); chk("A_swaps", r, 32'd4);
        csr_rd(4'd4, r); chk("A_passes", r, 32'd3);
        csr_rd(4'd1, r); chk("A_base_kept", r, 32'h6000);
        csr_rd(4'd2, r); chk("A_len_kept", r, 32'd4);
        chk("A_irq", 32'(bus.irq), 32'h1);
        csr_wr(4'd3, 32'h2);
        csr_rd(4'd3, r); chk("A_w1c", r, 32'h0);
        chk("A_irq_clr", 32'(bus.irq), 32'h0);

        // B: already sorted, no writes
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        base_wr = wr_cnt;
        csr_wr(4'd0, 32'h1);
        wait_done("B");
        csr_rd(4'd4, r); chk("B_passes", r, 32'd1);
        csr_rd(4'd5, r); chk("B_swaps", r, 32'd0);
        chk("B_writes", 32'(wr_cnt - base_wr), 32'd0);
        chk("B_irq_off", 32'(bus.irq), 32'h0);

        // C: descending signed [-2,7,0,-9]
        mem[0] = 32'hFFFFFFFE; mem[1] = 32'd7; mem[2] = 32'd0; mem[3] = 32'hFFFFFFF7;
        csr_wr(4'd0, 32'h7);
        wait_done("C");
        chk("C_m0", mem[0], 32'd7);
        chk("C_m1", mem[1], 32'd0);
        chk("C_m2", mem[2], 32'hFFFFFFFE);
        chk("C_m3", mem[3], 32'hFFFFFFF7);
        csr_rd(4'd5, r); chk("C_swaps", r, 32'd2);
        csr_rd(4'd4, r); chk("C_passes", r, 32'd2);

        // D: address wrap across 2^32
        mem[1022] = 4; mem[1023] = 3; mem[0] = 2; mem[1] = 1;
        csr_wr(4'd1, 32'hFFFFFFF8);
        csr_wr(4'd0, 32'h1);
        wait_done("D");
        chk("D_m0", mem[1022], 32'd1);
        chk("D_m1", mem[1023], 32'd2);
        chk("D_m2", mem[0], 32'd3);
        chk("D_m3", mem[1], 32'd4);
        csr_rd(4'd5, r); chk("D_swaps", r, 32'd6);

        // E: LEN=1 finishes without master traffic
        csr_wr(4'd2, 32'd1);
        base_rd = rd_cnt;
        csr_wr(4'd0, 32'h1);
        csr_rd(4'd3, r); chk("E_fast_done", r, 32'h2);
        chk("E_no_reads", 32'(rd_cnt - base_rd), 32'd0);
        csr_rd(4'd4, r); chk("E_passes", r, 32'd0);

        // F: random stalls and read latency, LEN above MAX_LEN clamps to 32
        rand_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            exp_arr[i] = mem[i];
        end
        for (int i = 32; i < 36; i++) mem[i] = 32'hA5A5A5A5;
        for (int i = 1; i < 32; i++) begin
            t = exp_arr[i];
            n = i - 1;
            while (n >= 0 && exp_arr[n] > t) begin
                exp_arr[n + 1] = exp_arr[n];
                n--;
            end
            exp_arr[n + 1] = t;
        end
        csr_wr(4'd1, 32'h0);
        csr_wr(4'd2, 32'd40);
        csr_rd(4'd2, r); chk("F_len_rb", r, 32'd40);
        csr_wr(4'd0, 32'h1);
        wait_done("F");
        for (int i = 0; i < 32; i++) chk($sformatf("F_m%0d", i), mem[i], exp_arr[i]);
        chk("F_clamp", mem[32], 32'hA5A5A5A5);
        chk("F_stall_stable", 32'(stall_viol), 32'd0);
        chk("F_stalls_seen", 32'(stall_cnt > 0), 32'd1);
        rand_mode = 1'b0;

        // G: reset while a swap write is stalled
        mem[0] = 2; mem[1] = 1;
        csr_wr(4'd2, 32'd2);
        csr_wr(4'd0, 32'h9);
        n = 0;
        while (bus.master_write !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("G_reached_wr", 32'(bus.master_write), 32'h1);
        force_wait = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("G_stall_wr", 32'(bus.master_write), 32'h1);
        chk("G_stall_wd", bus.master_writedata, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("G_rst_write", 32'(bus.master_write), 32'h0);
        chk("G_rst_read", 32'(bus.master_read), 32'h0);
        chk("G_rst_addr", bus.master_address, 32'h0);
        chk("G_rst_wd", bus.master_writedata, 32'h0);
        chk("G_rst_irq", 32'(bus.irq), 32'h0);
        @(negedge clk);
        force_wait = 1'b0;
        rst_n = 1'b1;
        csr_rd(4'd3, r); chk("G_status", r, 32'h0);
        csr_rd(4'd1, r); chk("G_base", r, 32'h0);
        mem[64] = 9; mem[65] = 8; mem[66] = 7;
        csr_wr(4'd1, 32'h100);
        csr_wr(4'd2, 32'd3);
        csr_wr(4'd0, 32'h1);
        wait_done("G");
        chk("G_m0", mem[64], 32'd7);
        chk("G_m1", mem[65], 32'd8);
        chk("G_m2", mem[66], 32'd9);
        csr_rd(4'd5, r); chk("G_swaps", r, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
